// File: rtl/block_sync_seeker_if.sv
`default_nettype none
// ============================================================================
// Module   : block_sync_seeker_if
// Purpose  : Gearbox-side input and aligned-block output bundle of the seeker.
// Revision : 1.0 - initial release
// ============================================================================
interface block_sync_seeker_if #(
    parameter int BLOCK_W  = 66,
    parameter int BUF_W    = 194,
    parameter int OFFSET_W = $clog2(BLOCK_W)
) ();
    logic                buffer_dv;
    logic [BUF_W-1:0]    gbox_buffer;
    logic                resync_i;
    logic [OFFSET_W-1:0] block_offset;
    logic                locked_o;
    logic                slip_o;
    logic                block_dv_o;
    logic [BLOCK_W-1:0]  block_o;
    logic                hdr_err_o;

    modport master (
        output buffer_dv, gbox_buffer, resync_i,
        input  block_offset, locked_o, slip_o, block_dv_o, block_o, hdr_err_o
    );

    modport slave (
        input  buffer_dv, gbox_buffer, resync_i,
        output block_offset, locked_o, slip_o, block_dv_o, block_o, hdr_err_o
    );
endinterface
`default_nettype wire

// File: rtl/block_sync_seeker.sv
`default_nettype none
// ============================================================================
// Module   : block_sync_seeker
// Purpose  : Hunts, verifies and monitors the 64b/66b sync-header offset in
//            the gearbox buffer and emits the aligned block while locked.
// Revision : 1.0 - initial release
// ============================================================================
module block_sync_seeker #(
    parameter int BLOCK_W   = 66,
    parameter int BUF_W     = 194,
    parameter int OFFSET_W  = $clog2(BLOCK_W),
    parameter int SCAN_MODE = 0,
    parameter int LOCK_CNT  = 32,
    parameter int WINDOW    = 64,
    parameter int ERR_LIMIT = 16,
    parameter int SLIP_HOLD = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    block_sync_seeker_if.slave bus
);
    localparam int c_GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int c_WIN_W  = $clog2(WINDOW + 1);
    localparam int c_ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int c_HOLD_W = (SLIP_HOLD > 0) ? $clog2(SLIP_HOLD + 1) : 1;

    localparam logic [1:0] c_HUNT   = 2'd0;
    localparam logic [1:0] c_VERIFY = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    localparam logic [OFFSET_W-1:0] c_OFF_ONE  = OFFSET_W'(1);
    localparam logic [OFFSET_W-1:0] c_OFF_LAST = OFFSET_W'(BLOCK_W - 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_ONE = c_GOOD_W'(1);
    localparam logic [c_WIN_W-1:0]  c_WIN_ONE  = c_WIN_W'(1);
    localparam logic [c_ERR_W-1:0]  c_ERR_ONE  = c_ERR_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);

    logic [1:0]          r_state, w_state_nxt;
    logic [OFFSET_W-1:0] r_offset, w_offset_nxt;
    logic [c_GOOD_W-1:0] r_good_cnt, w_good_nxt;
    logic [c_WIN_W-1:0]  r_win_cnt, w_win_nxt;
    logic [c_ERR_W-1:0]  r_err_cnt, w_err_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt, w_hold_nxt;

    logic                r_locked, w_locked_nxt;
    logic                r_slip, w_slip_nxt;
    logic                r_block_dv, w_block_dv_nxt;
    logic                r_hdr_err, w_hdr_err_nxt;
    logic [BLOCK_W-1:0]  r_block, w_block_nxt;

    logic [BUF_W-1:0]    w_buf;
    logic [BLOCK_W-1:0]  w_hdr_ok;
    logic                w_cur_ok;
    logic                w_eval;
    logic                w_slip_req;
    logic                w_do_slip;
    logic [OFFSET_W-1:0] w_cand;
    logic                w_cand_found;

    assign w_buf    = bus.gbox_buffer;
    assign w_cur_ok = w_hdr_ok[r_offset];
    assign w_eval   = bus.buffer_dv && !bus.resync_i && (r_hold_cnt == '0);

    // A 2-bit header is legal exactly when its two bits differ.
    always_comb begin
        w_hdr_ok = '0;
        for (int k = 0; k < BLOCK_W; k++) begin
            w_hdr_ok[k] = w_buf[k] ^ w_buf[k + 1];
        end
    end

    generate
        if (BUF_W > 2 * BLOCK_W - 1) begin : g_unused_tail
            logic w_unused_tail;
            assign w_unused_tail = ^w_buf[BUF_W-1:2*BLOCK_W-1];
        end

        if (SCAN_MODE == 0) begin : g_seq_slip
            always_comb begin
                w_cand_found = 1'b1;
                w_cand       = (r_offset == c_OFF_LAST) ? '0 : r_offset + c_OFF_ONE;
            end
        end else begin : g_scan_slip
            logic [OFFSET_W:0] w_sum;
            // Walk distances from far to near so the nearest legal offset wins.
            always_comb begin
                w_cand       = r_offset;
                w_cand_found = 1'b0;
                w_sum        = '0;
                for (int i = BLOCK_W - 1; i >= 1; i--) begin
                    w_sum = {1'b0, r_offset} + (OFFSET_W + 1)'(i);
                    if (w_sum >= (OFFSET_W + 1)'(BLOCK_W)) begin
                        w_sum = w_sum - (OFFSET_W + 1)'(BLOCK_W);
                    end
                    if (w_hdr_ok[w_sum[OFFSET_W-1:0]]) begin
                        w_cand       = w_sum[OFFSET_W-1:0];
                        w_cand_found = 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_good_nxt   = r_good_cnt;
        w_win_nxt    = r_win_cnt;
        w_err_nxt    = r_err_cnt;
        w_hold_nxt   = r_hold_cnt;
        w_slip_req   = 1'b0;
        w_do_slip    = 1'b0;
        if (bus.resync_i) begin
            w_state_nxt = c_HUNT;
            w_good_nxt  = '0;
            w_win_nxt   = '0;
            w_err_nxt   = '0;
            w_hold_nxt  = '0;
        end else if (bus.buffer_dv) begin
            if (r_hold_cnt != '0) begin
                w_hold_nxt = r_hold_cnt - c_HOLD_ONE;
            end else begin
                case (r_state)
                    c_HUNT: begin
                        if (w_cur_ok) begin
                            w_good_nxt  = c_GOOD_ONE;
                            w_state_nxt = (LOCK_CNT == 1) ? c_LOCKED : c_VERIFY;
                        end else begin
                            w_slip_req = 1'b1;
                        end
                    end
                    c_VERIFY: begin
                        if (!w_cur_ok) begin
                            w_good_nxt  = '0;
                            w_state_nxt = c_HUNT;
                            w_slip_req  = 1'b1;
                        end else if (r_good_cnt >= c_GOOD_W'(LOCK_CNT - 1)) begin
                            w_good_nxt  = c_GOOD_W'(LOCK_CNT);
                            w_state_nxt = c_LOCKED;
                        end else begin
                            w_good_nxt = r_good_cnt + c_GOOD_ONE;
                        end
                    end
                    c_LOCKED: begin
                        // Losing lock outranks the window wrap on the same beat.
                        if (!w_cur_ok && (r_err_cnt >= c_ERR_W'(ERR_LIMIT - 1))) begin
                            w_state_nxt = c_HUNT;
                            w_good_nxt  = '0;
                            w_win_nxt   = '0;
                            w_err_nxt   = '0;
                        end else begin
                            if (!w_cur_ok) begin
                                w_err_nxt = r_err_cnt + c_ERR_ONE;
                            end
                            if (r_win_cnt >= c_WIN_W'(WINDOW - 1)) begin
                                w_win_nxt = '0;
                                w_err_nxt = '0;
                            end else begin
                                w_win_nxt = r_win_cnt + c_WIN_ONE;
                            end
                        end
                    end
                    default: w_state_nxt = c_HUNT;
                endcase
                if (w_slip_req && w_cand_found) begin
                    w_offset_nxt = w_cand;
                    w_hold_nxt   = c_HOLD_W'(SLIP_HOLD);
                    w_do_slip    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_locked_nxt   = (w_state_nxt == c_LOCKED);
        w_slip_nxt     = w_do_slip;
        w_block_dv_nxt = w_eval && (r_state == c_LOCKED);
        w_hdr_err_nxt  = w_block_dv_nxt && !w_cur_ok;
        w_block_nxt    = w_block_dv_nxt ? w_buf[r_offset +: BLOCK_W] : r_block;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_HUNT;
            r_offset   <= '0;
            r_good_cnt <= '0;
            r_win_cnt  <= '0;
            r_err_cnt  <= '0;
            r_hold_cnt <= '0;
            r_locked   <= 1'b0;
            r_slip     <= 1'b0;
            r_block_dv <= 1'b0;
            r_hdr_err  <= 1'b0;
            r_block    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_offset   <= w_offset_nxt;
            r_good_cnt <= w_good_nxt;
            r_win_cnt  <= w_win_nxt;
            r_err_cnt  <= w_err_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_locked   <= w_locked_nxt;
            r_slip     <= w_slip_nxt;
            r_block_dv <= w_block_dv_nxt;
            r_hdr_err  <= w_hdr_err_nxt;
            r_block    <= w_block_nxt;
        end
    end

    assign bus.block_offset = r_offset;
    assign bus.locked_o     = r_locked;
    assign bus.slip_o       = r_slip;
    assign bus.block_dv_o   = r_block_dv;
    assign bus.block_o      = r_block;
    assign bus.hdr_err_o    = r_hdr_err;
endmodule
`default_nettype wire

// File: tb/tb_block_sync_seeker.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_sync_seeker
// Purpose  : Scoreboard bench driving a slip-mode and a scan-mode seeker with
//            the same stimulus and checking both against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_sync_seeker;
    localparam int BLOCK_W   = 66;
    localparam int BUF_W     = 194;
    localparam int OW        = 7;
    localparam int LOCK_CNT  = 32;
    localparam int WINDOW    = 64;
    localparam int ERR_LIMIT = 16;
    localparam int SLIP_HOLD = 2;

    typedef struct packed {
        logic               locked;
        logic               slip;
        logic               dv;
        logic               herr;
        logic [OW-1:0]      off;
        logic [BLOCK_W-1:0] blk;
    } rec_t;
    typedef rec_t [1:0] pair_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             dv;
    logic             rs;
    logic [BUF_W-1:0] gbuf;

    int n_checks = 0;
    int n_pass   = 0;
    int slip_cnt[2];
    int herr_cnt[2];

    pair_t              st_q[$];
    logic [BLOCK_W:0]   blk_q[2][$];

    int m_state[2];
    int m_off[2];
    int m_good[2];
    int m_win[2];
    int m_err[2];
    int m_hold[2];

    always #5 clk = ~clk;

    block_sync_seeker_if #(.BLOCK_W(BLOCK_W), .BUF_W(BUF_W), .OFFSET_W(OW)) bif0 ();
    block_sync_seeker_if #(.BLOCK_W(BLOCK_W), .BUF_W(BUF_W), .OFFSET_W(OW)) bif1 ();

    assign bif0.buffer_dv   = dv;
    assign bif0.gbox_buffer = gbuf;
    assign bif0.resync_i    = rs;
    assign bif1.buffer_dv   = dv;
    assign bif1.gbox_buffer = gbuf;
    assign bif1.resync_i    = rs;

    block_sync_seeker #(
        .BLOCK_W(BLOCK_W), .BUF_W(BUF_W), .OFFSET_W(OW), .SCAN_MODE(0),
        .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIMIT), .SLIP_HOLD(SLIP_HOLD)
    ) dut_slip (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bif0)
    );

    block_sync_seeker #(
        .BLOCK_W(BLOCK_W), .BUF_W(BUF_W), .OFFSET_W(OW), .SCAN_MODE(1),
        .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIMIT), .SLIP_HOLD(SLIP_HOLD)
    ) dut_scan (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bif1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit hdr_ok(input logic [BUF_W-1:0] b, input int k);
        return b[k] != b[k+1];
    endfunction

    // Next offset under the slip rule of each mode; returns the current one if none.
    function automatic int pick(input int m, input logic [BUF_W-1:0] b, input int off);
        if (m == 0) return (off + 1) % BLOCK_W;
        for (int d = 1; d < BLOCK_W; d++) begin
            if (hdr_ok(b, (off + d) % BLOCK_W)) return (off + d) % BLOCK_W;
        end
        return off;
    endfunction

    task automatic model_step(input int m, output rec_t e);
        bit ok;
        int n;
        e = '0;
        if (rst) begin
            m_state[m] = 0; m_off[m] = 0; m_good[m] = 0;
            m_win[m] = 0; m_err[m] = 0; m_hold[m] = 0;
        end else if (rs) begin
            m_state[m] = 0; m_good[m] = 0; m_win[m] = 0; m_err[m] = 0; m_hold[m] = 0;
        end else if (dv) begin
            if (m_hold[m] > 0) begin
                m_hold[m]--;
            end else begin
                ok = hdr_ok(gbuf, m_off[m]);
                if (m_state[m] == 2) begin
                    e.dv   = 1'b1;
                    e.blk  = gbuf[m_off[m] +: BLOCK_W];
                    e.herr = !ok;
                    if (!ok) m_err[m]++;
                    if (m_err[m] == ERR_LIMIT) begin
                        m_state[m] = 0; m_good[m] = 0; m_win[m] = 0; m_err[m] = 0;
                    end else begin
                        m_win[m]++;
                        if (m_win[m] == WINDOW) begin
                            m_win[m] = 0; m_err[m] = 0;
                        end
                    end
                end else if (ok) begin
                    m_good[m]++;
                    m_state[m] = (m_good[m] == LOCK_CNT) ? 2 : 1;
                end else begin
                    m_good[m]  = 0;
                    m_state[m] = 0;
                    n = pick(m, gbuf, m_off[m]);
                    if (n != m_off[m]) begin
                        m_off[m]  = n;
                        m_hold[m] = SLIP_HOLD;
                        e.slip    = 1'b1;
                    end
                end
            end
        end
        e.locked = (m_state[m] == 2);
        e.off    = OW'(m_off[m]);
    endtask

    // Expected responses are produced from the inputs presented at each edge.
    initial begin
        pair_t p;
        rec_t  e;
        forever begin
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                model_step(m, e);
                p[m] = e;
                if (e.dv) blk_q[m].push_back({e.herr, e.blk});
            end
            st_q.push_back(p);
        end
    end

    initial begin
        pair_t              p;
        logic               a_lock, a_slip, a_dv, a_herr;
        logic [OW-1:0]      a_off;
        logic [BLOCK_W-1:0] a_blk;
        logic [BLOCK_W:0]   eb;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (st_q.size() == 0) begin
                chk("status_queue_nonempty", 0, 1);
            end else begin
                p = st_q.pop_front();
                for (int m = 0; m < 2; m++) begin
                    if (m == 0) begin
                        a_lock = bif0.locked_o; a_slip = bif0.slip_o; a_dv = bif0.block_dv_o;
                        a_herr = bif0.hdr_err_o; a_off = bif0.block_offset; a_blk = bif0.block_o;
                    end else begin
                        a_lock = bif1.locked_o; a_slip = bif1.slip_o; a_dv = bif1.block_dv_o;
                        a_herr = bif1.hdr_err_o; a_off = bif1.block_offset; a_blk = bif1.block_o;
                    end
                    chk($sformatf("status_dut%0d{lock,slip,dv,herr,off}", m),
                        {a_lock, a_slip, a_dv, a_herr, a_off},
                        {p[m].locked, p[m].slip, p[m].dv, p[m].herr, p[m].off});
                    if (a_dv) begin
                        if (blk_q[m].size() == 0) begin
                            chk($sformatf("block_dut%0d_expected_present", m), 0, 1);
                        end else begin
                            eb = blk_q[m].pop_front();
                            chk($sformatf("block_dut%0d{herr,block}", m), {a_herr, a_blk}, eb);
                        end
                    end
                    if (a_slip) slip_cnt[m]++;
                    if (a_herr) herr_cnt[m]++;
                end
            end
        end
    end

    task automatic drive(input logic r, input logic d, input logic s, input logic [BUF_W-1:0] b);
        rst = r; dv = d; rs = s; gbuf = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BUF_W-1:0] bit6_buf(input bit bad);
        logic [BUF_W-1:0] b;
        b    = '0;
        b[6] = 1'b1;
        if (bad) b[5] = 1'b1;
        return b;
    endfunction

    function automatic logic [BUF_W-1:0] rand_buf(input int t, input int err_pct);
        logic [BUF_W-1:0] b;
        for (int i = 0; i < BUF_W; i++) b[i] = 1'($urandom_range(0, 1));
        b[t + 1] = ~b[t];
        if ($urandom_range(0, 99) < err_pct) b[t + 1] = b[t];
        return b;
    endfunction

    initial begin
        logic [BUF_W-1:0] good5;
        logic [BUF_W-1:0] bad5;
        int               s0, s1;
        good5 = bit6_buf(1'b0);
        bad5  = bit6_buf(1'b1);

        drive(1'b1, 1'b1, 1'b0, good5);
        drive(1'b1, 1'b0, 1'b0, good5);
        chk("reset_outputs_slip", {bif0.locked_o, bif0.slip_o, bif0.block_dv_o, bif0.hdr_err_o, bif0.block_offset}, 0);
        chk("reset_outputs_scan", {bif1.locked_o, bif1.slip_o, bif1.block_dv_o, bif1.hdr_err_o, bif1.block_offset}, 0);
        slip_cnt = '{0, 0};

        for (int beat = 1; beat <= 48; beat++) begin
            drive(1'b0, 1'b1, 1'b0, good5);
            if (beat == 1) begin
                chk("slip_first_offset", bif0.block_offset, 1);
                chk("scan_jump_offset", bif1.block_offset, 5);
                chk("scan_jump_pulse", bif1.slip_o, 1);
            end
            if (beat == 13) chk("slip_reaches_5", bif0.block_offset, 5);
            if (beat == 34) chk("scan_not_locked_34", bif1.locked_o, 0);
            if (beat == 35) chk("scan_locked_35", bif1.locked_o, 1);
            if (beat == 36) chk("scan_block_hdr", {bif1.block_dv_o, bif1.block_o[1:0]}, 3'b110);
            if (beat == 46) chk("slip_not_locked_46", bif0.locked_o, 0);
            if (beat == 47) chk("slip_locked_47", bif0.locked_o, 1);
            if (beat == 48) chk("slip_block_hdr", {bif0.block_dv_o, bif0.block_o[1:0]}, 3'b110);
            repeat (7) drive(1'b0, 1'b0, 1'b0, good5);
        end
        chk("slip_count_seq", slip_cnt[0], 5);
        chk("slip_count_scan", slip_cnt[1], 1);

        drive(1'b0, 1'b1, 1'b1, good5);
        chk("resync_slip", {bif0.block_dv_o, bif0.locked_o, bif0.block_offset}, 5);
        chk("resync_scan", {bif1.block_dv_o, bif1.locked_o, bif1.block_offset}, 5);
        s0 = slip_cnt[0];
        s1 = slip_cnt[1];
        for (int i = 1; i <= LOCK_CNT; i++) begin
            drive(1'b0, 1'b1, 1'b0, good5);
            if (i == LOCK_CNT - 1) chk("relock_not_yet", {bif0.locked_o, bif1.locked_o}, 0);
        end
        chk("relock_both", {bif0.locked_o, bif1.locked_o}, 2'b11);
        drive(1'b0, 1'b0, 1'b0, good5);
        chk("relock_no_slip", slip_cnt[0] + slip_cnt[1], s0 + s1);

        herr_cnt = '{0, 0};
        repeat (15) drive(1'b0, 1'b1, 1'b0, bad5);
        repeat (2) drive(1'b0, 1'b0, 1'b0, good5);
        chk("tolerate_15_lock", {bif0.locked_o, bif1.locked_o}, 2'b11);
        chk("tolerate_15_errs", herr_cnt[0], 15);
        repeat (WINDOW - 15) drive(1'b0, 1'b1, 1'b0, good5);
        repeat (15) drive(1'b0, 1'b1, 1'b0, bad5);
        drive(1'b0, 1'b0, 1'b0, good5);
        chk("window_clear_lock", {bif0.locked_o, bif1.locked_o}, 2'b11);
        repeat (15) drive(1'b0, 1'b1, 1'b0, good5);
        drive(1'b0, 1'b1, 1'b0, bad5);
        chk("unlock_16th_slip", {bif0.locked_o, bif0.hdr_err_o, bif0.block_dv_o, bif0.block_offset}, {3'b011, 7'd5});
        chk("unlock_16th_scan", {bif1.locked_o, bif1.hdr_err_o, bif1.block_dv_o, bif1.block_offset}, {3'b011, 7'd5});

        for (int seg = 0; seg < 8; seg++) begin
            int t;
            int ep;
            t  = $urandom_range(0, BLOCK_W - 1);
            ep = (seg % 3 == 2) ? 35 : 2;
            for (int c = 0; c < 500; c++) begin
                drive(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 299) == 0), rand_buf(t, ep));
            end
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0, good5);
        @(negedge clk);
        #1;
        chk("status_queue_drained", st_q.size(), 0);
        chk("block_queue_drained", blk_q[0].size() + blk_q[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
